// File: rtl/z80fi_insn_packer.sv
// Collects the opcode bytes and architectural state of each retired Z80 instruction
// and emits one registered z80fi packet per instruction, plus a one-cycle protocol error pulse.
module z80fi_insn_packer #(
    parameter int REGS_W  = 224,
    parameter int MAX_LEN = 4,
    parameter int ORDER_W = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 insn_start,
    input  logic                 insn_done,
    input  logic                 byte_valid,
    input  logic [7:0]           byte_data,
    input  logic [REGS_W-1:0]    core_regs,
    output logic                 z80fi_valid,
    output logic [ORDER_W-1:0]   z80fi_order,
    output logic [8*MAX_LEN-1:0] z80fi_insn,
    output logic [2:0]           z80fi_insn_len,
    output logic [REGS_W-1:0]    z80fi_regs_in,
    output logic [REGS_W-1:0]    z80fi_regs_out,
    output logic                 z80fi_overflow,
    output logic                 z80fi_error
);

    localparam int INSN_W = 8 * MAX_LEN;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_COLLECT = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [INSN_W-1:0]    r_buf;
    logic [2:0]           r_len;
    logic                 r_ovf;
    logic [REGS_W-1:0]    r_regs_in;
    logic [ORDER_W-1:0]   r_order_cnt;

    logic                 r_valid;
    logic                 r_err;
    logic [ORDER_W-1:0]   r_pkt_order;
    logic [INSN_W-1:0]    r_pkt_insn;
    logic [2:0]           r_pkt_len;
    logic [REGS_W-1:0]    r_pkt_regs_in;
    logic [REGS_W-1:0]    r_pkt_regs_out;
    logic                 r_pkt_ovf;

    logic                 w_append;
    logic [INSN_W-1:0]    w_pkt_buf;
    logic [2:0]           w_pkt_len;
    logic                 w_pkt_ovf;
    logic                 w_emit;
    logic                 w_err;

    // A byte arriving together with insn_start belongs to the new instruction, not the open one.
    assign w_append = (r_state == S_COLLECT) && byte_valid && !insn_start;

    // Contents of the open instruction including any byte fetched this cycle.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        w_pkt_buf = r_buf;
        w_pkt_len = r_len;
        w_pkt_ovf = r_ovf;
        if (w_append) begin
            if (r_len < 3'(MAX_LEN)) begin
                for (int i = 0; i < MAX_LEN; i++) begin
                    if (r_len == 3'(i)) w_pkt_buf[8*i +: 8] = byte_data;
                end
                w_pkt_len = r_len + 3'd1;
            end else begin
                w_pkt_ovf = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_emit       = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (insn_done || (byte_valid && !insn_start)) w_err = 1'b1;
                if (insn_start) w_state_next = S_COLLECT;
            end
            S_COLLECT: begin
                if (insn_done) begin
                    w_state_next = insn_start ? S_COLLECT : S_IDLE;
                    if (w_pkt_len == 3'd0) w_err  = 1'b1;
                    else                   w_emit = 1'b1;
                end else if (insn_start) begin
                    w_err = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_buf          <= '0;
            r_len          <= '0;
            r_ovf          <= 1'b0;
            r_regs_in      <= '0;
            r_order_cnt    <= '0;
            r_valid        <= 1'b0;
            r_err          <= 1'b0;
            r_pkt_order    <= '0;
            r_pkt_insn     <= '0;
            r_pkt_len      <= '0;
            r_pkt_regs_in  <= '0;
            r_pkt_regs_out <= '0;
            r_pkt_ovf      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_valid <= w_emit;
            r_err   <= w_err;

            if (insn_start) begin
                r_regs_in <= core_regs;
                r_buf     <= byte_valid ? INSN_W'(byte_data) : '0;
                r_len     <= {2'b00, byte_valid};
                r_ovf     <= 1'b0;
            end else if (r_state == S_COLLECT) begin
                r_buf <= w_pkt_buf;
                r_len <= w_pkt_len;
                r_ovf <= w_pkt_ovf;
            end

            // Packet fields persist until the next packet; only the strobe drops.
            if (w_emit) begin
                r_pkt_order    <= r_order_cnt;
                r_pkt_insn     <= w_pkt_buf;
                r_pkt_len      <= w_pkt_len;
                r_pkt_regs_in  <= r_regs_in;
                r_pkt_regs_out <= core_regs;
                r_pkt_ovf      <= w_pkt_ovf;
                r_order_cnt    <= r_order_cnt + 1'b1;
            end
        end
    end

    assign z80fi_valid    = r_valid;
    assign z80fi_order    = r_pkt_order;
    assign z80fi_insn     = r_pkt_insn;
    assign z80fi_insn_len = r_pkt_len;
    assign z80fi_regs_in  = r_pkt_regs_in;
    assign z80fi_regs_out = r_pkt_regs_out;
    assign z80fi_overflow = r_pkt_ovf;
    assign z80fi_error    = r_err;

endmodule

// File: tb/tb_z80fi_insn_packer.sv
// Bench for z80fi_insn_packer: directed protocol scenarios followed by random traffic,
// checked against a byte-queue model of the packet rules; a second instance uses ORDER_W=2.
module tb_z80fi_insn_packer;

    localparam int REGS_W = 224;

    logic              clk;
    logic              reset_n;
    logic              insn_start;
    logic              insn_done;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic [REGS_W-1:0] core_regs;

    logic              z80fi_valid;
    logic [15:0]       z80fi_order;
    logic [31:0]       z80fi_insn;
    logic [2:0]        z80fi_insn_len;
    logic [REGS_W-1:0] z80fi_regs_in;
    logic [REGS_W-1:0] z80fi_regs_out;
    logic              z80fi_overflow;
    logic              z80fi_error;

    logic              s_valid;
    logic [1:0]        s_order;
    logic [31:0]       s_insn;
    logic [2:0]        s_insn_len;
    logic [REGS_W-1:0] s_regs_in;
    logic [REGS_W-1:0] s_regs_out;
    logic              s_overflow;
    logic              s_error;

    z80fi_insn_packer #(.REGS_W(REGS_W), .MAX_LEN(4), .ORDER_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .insn_start(insn_start), .insn_done(insn_done),
        .byte_valid(byte_valid), .byte_data(byte_data), .core_regs(core_regs),
        .z80fi_valid(z80fi_valid), .z80fi_order(z80fi_order), .z80fi_insn(z80fi_insn),
        .z80fi_insn_len(z80fi_insn_len), .z80fi_regs_in(z80fi_regs_in),
        .z80fi_regs_out(z80fi_regs_out), .z80fi_overflow(z80fi_overflow), .z80fi_error(z80fi_error)
    );

    z80fi_insn_packer #(.REGS_W(REGS_W), .MAX_LEN(4), .ORDER_W(2)) dut_small (
        .clk(clk), .reset_n(reset_n), .insn_start(insn_start), .insn_done(insn_done),
        .byte_valid(byte_valid), .byte_data(byte_data), .core_regs(core_regs),
        .z80fi_valid(s_valid), .z80fi_order(s_order), .z80fi_insn(s_insn),
        .z80fi_insn_len(s_insn_len), .z80fi_regs_in(s_regs_in),
        .z80fi_regs_out(s_regs_out), .z80fi_overflow(s_overflow), .z80fi_error(s_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: the open instruction is an unbounded byte queue.
    bit                m_open;
    byte unsigned      m_bytes[$];
    logic [REGS_W-1:0] m_regs_in;
    int                m_count;

    logic              e_valid;
    logic [15:0]       e_order;
    logic [31:0]       e_insn;
    logic [2:0]        e_len;
    logic [REGS_W-1:0] e_regs_in;
    logic [REGS_W-1:0] e_regs_out;
    logic              e_ovf;
    logic              e_err;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [REGS_W-1:0] rand_regs();
        logic [REGS_W-1:0] r;
        for (int i = 0; i < REGS_W / 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic check_all();
        check("valid",     256'(z80fi_valid),    256'(e_valid));
        check("error",     256'(z80fi_error),    256'(e_err));
        check("order",     256'(z80fi_order),    256'(e_order));
        check("insn",      256'(z80fi_insn),     256'(e_insn));
        check("insn_len",  256'(z80fi_insn_len), 256'(e_len));
        check("overflow",  256'(z80fi_overflow), 256'(e_ovf));
        check("regs_in",   256'(z80fi_regs_in),  256'(e_regs_in));
        check("regs_out",  256'(z80fi_regs_out), 256'(e_regs_out));
        check("s_valid",   256'(s_valid),        256'(e_valid));
        check("s_error",   256'(s_error),        256'(e_err));
        check("s_order",   256'(s_order),        256'(e_order[1:0]));
    endtask

    task automatic model_clear();
        m_open = 1'b0;
        m_bytes.delete();
        m_regs_in = '0;
        m_count = 0;
        e_valid = 1'b0; e_order = '0; e_insn = '0; e_len = '0;
        e_regs_in = '0; e_regs_out = '0; e_ovf = 1'b0; e_err = 1'b0;
    endtask

    task automatic model_cycle(input bit s, input bit d, input bit bv, input byte unsigned bd,
                               input logic [REGS_W-1:0] rg);
        int n;
        e_valid = 1'b0;
        e_err   = 1'b0;
        if (!m_open) begin
            if (d) e_err = 1'b1;
            if (bv && !s) e_err = 1'b1;
        end else if (d) begin
            if (bv && !s) m_bytes.push_back(bd);
            if (m_bytes.size() == 0) begin
                e_err = 1'b1;
            end else begin
                n = (m_bytes.size() > 4) ? 4 : m_bytes.size();
                e_valid = 1'b1;
                e_insn  = '0;
                for (int i = 0; i < n; i++) e_insn[8*i +: 8] = m_bytes[i];
                e_len      = 3'(n);
                e_ovf      = (m_bytes.size() > 4);
                e_regs_in  = m_regs_in;
                e_regs_out = rg;
                e_order    = 16'(m_count);
                m_count++;
            end
            m_open = 1'b0;
        end else if (s) begin
            e_err = 1'b1;
        end else if (bv) begin
            m_bytes.push_back(bd);
        end
        if (s) begin
            m_open = 1'b1;
            m_bytes.delete();
            if (bv) m_bytes.push_back(bd);
            m_regs_in = rg;
        end
    endtask

    task automatic step(input bit s, input bit d, input bit bv, input byte unsigned bd,
                        input logic [REGS_W-1:0] rg);
        @(negedge clk);
        reset_n = 1'b1; insn_start = s; insn_done = d; byte_valid = bv; byte_data = bd; core_regs = rg;
        model_cycle(s, d, bv, bd, rg);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset(input bit s, input bit d, input bit bv);
        @(negedge clk);
        reset_n = 1'b0; insn_start = s; insn_done = d; byte_valid = bv;
        byte_data = 8'($urandom); core_regs = rand_regs();
        model_clear();
        @(posedge clk);
        #1;
        check_all();
    endtask

    logic [REGS_W-1:0] rg;

    initial begin
        reset_n = 1'b0; insn_start = 1'b0; insn_done = 1'b0; byte_valid = 1'b0;
        byte_data = '0; core_regs = '0;
        model_clear();
        do_reset(1'b0, 1'b0, 1'b0);
        step(0, 0, 0, 8'h00, rand_regs());

        // LD A,R
        step(1, 0, 1, 8'hED, rand_regs());
        step(0, 0, 1, 8'h5F, rand_regs());
        rg = rand_regs();
        rg[7:0] = 8'h80;
        step(0, 1, 0, 8'h00, rg);
        check("ldar_insn", 256'(z80fi_insn), 256'(32'h0000_5FED));
        step(0, 0, 0, 8'h00, rand_regs());

        // Back-to-back NOPs with coincident start/done
        step(1, 0, 1, 8'h00, rand_regs());
        step(1, 1, 1, 8'h00, rand_regs());
        step(1, 1, 1, 8'h00, rand_regs());
        step(0, 1, 0, 8'h00, rand_regs());
        step(0, 0, 0, 8'h00, rand_regs());

        // Five-byte sequence truncated to four
        step(1, 0, 1, 8'hDD, rand_regs());
        step(0, 0, 1, 8'hCB, rand_regs());
        step(0, 0, 1, 8'h05, rand_regs());
        step(0, 0, 1, 8'h06, rand_regs());
        step(0, 0, 1, 8'hFF, rand_regs());
        step(0, 1, 0, 8'h00, rand_regs());
        check("ovf_insn", 256'(z80fi_insn), 256'(32'h0605_CBDD));
        step(0, 0, 0, 8'h00, rand_regs());

        // Protocol violations
        step(0, 1, 0, 8'h00, rand_regs());
        step(0, 0, 1, 8'h3C, rand_regs());
        step(1, 0, 1, 8'h3E, rand_regs());
        step(1, 0, 1, 8'h04, rand_regs());
        step(0, 1, 0, 8'h00, rand_regs());
        step(1, 0, 0, 8'h00, rand_regs());
        step(0, 1, 0, 8'h00, rand_regs());
        step(1, 1, 1, 8'h76, rand_regs());
        step(0, 1, 0, 8'h00, rand_regs());
        step(0, 0, 0, 8'h00, rand_regs());

        // Reset while an instruction is open, and while a strobe is pending
        step(1, 0, 1, 8'hED, rand_regs());
        do_reset(0, 1, 0);
        step(0, 0, 0, 8'h00, rand_regs());
        step(1, 0, 1, 8'h01, rand_regs());
        step(0, 1, 0, 8'h00, rand_regs());
        do_reset(0, 0, 0);

        // Five packets: the narrow counter wraps 0,1,2,3,0
        for (int k = 0; k < 5; k++) begin
            step(1, 0, 1, 8'(k), rand_regs());
            step(0, 1, 0, 8'h00, rand_regs());
        end
        step(0, 0, 0, 8'h00, rand_regs());

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset(1'($urandom), 1'($urandom), 1'($urandom));
            end else begin
                step($urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
                     1'($urandom), 8'($urandom), rand_regs());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
